// File: rtl/dma_ring_engine_if.sv
// dma_ring_engine_if: read/write burst channels between the DMA engine
// (master) and the memory fabric (slave).
interface dma_ring_engine_if #(
   parameter int DATA_WIDTH = 32
);
   logic [31:0]           rd_req_addr;
   logic [4:0]            rd_req_len;
   logic                  rd_req_valid;
   logic                  rd_req_ready;
   logic [DATA_WIDTH-1:0] rd_rdata;
   logic                  rd_valid;
   logic                  rd_last;
   logic                  rd_ready;
   logic [31:0]           wr_req_addr;
   logic [4:0]            wr_req_len;
   logic                  wr_req_valid;
   logic                  wr_req_ready;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_valid;
   logic                  wr_last;
   logic                  wr_ready;

   modport master (
      output rd_req_addr, rd_req_len, rd_req_valid, rd_ready,
      output wr_req_addr, wr_req_len, wr_req_valid,
      output wr_data, wr_valid, wr_last,
      input  rd_req_ready, rd_rdata, rd_valid, rd_last,
      input  wr_req_ready, wr_ready
   );

   modport slave (
      input  rd_req_addr, rd_req_len, rd_req_valid, rd_ready,
      input  wr_req_addr, wr_req_len, wr_req_valid,
      input  wr_data, wr_valid, wr_last,
      output rd_req_ready, rd_rdata, rd_valid, rd_last,
      output wr_req_ready, wr_ready
   );
endinterface

// File: rtl/dma_ring_engine.sv
// dma_ring_engine: ring-buffer memory-to-memory DMA with burst staging.
// Define DMA_PERF_CNT_EN to add busy-cycle and burst performance counters.
module dma_ring_engine #(
   parameter int DATA_WIDTH  = 32,
   parameter int BURST_BEATS = 8,
   parameter int RING_BYTES  = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  reg_wr_en,
   input  logic [31:0] reg_wr_data,
   output logic [31:0] src_base,
   output logic [31:0] dest_base,
   output logic [31:0] tail_ptr,
   output logic [31:0] head_ptr,
   output logic [31:0] dma_size,
   output logic [31:0] ctrl_stat,
   output logic        intr,
   output logic        busy,
`ifdef DMA_PERF_CNT_EN
   output logic [31:0] perf_cycles,
   output logic [31:0] perf_bursts,
`endif
   dma_ring_engine_if.master bus
);
   localparam int BW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
   localparam logic [BW-1:0] LAST = BW'(BURST_BEATS - 1);
   localparam logic [31:0] BURST_BYTES = 32'(BURST_BEATS * DATA_WIDTH / 8);
   localparam logic [31:0] RING_MASK = 32'(RING_BYTES - 1);

   typedef enum logic [2:0] {
      IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, DONE
   } state_t;

   state_t state_q, state_d;
   logic                  drain_q;
   logic [31:0]           offset_q;
   logic [31:0]           offset_next;
   logic [BW-1:0]         beat_q;
   logic [BW-1:0]         beat_inc;
   logic [DATA_WIDTH-1:0] data_buf [BURST_BEATS];
   logic                  start;
   logic                  burst_done;

   assign intr        = ctrl_stat[31];
   assign busy        = (state_q != IDLE);
   assign beat_inc    = (beat_q == LAST) ? '0 : beat_q + 1'b1;
   assign offset_next = offset_q + BURST_BYTES;
   assign start       = ctrl_stat[0] && (head_ptr != tail_ptr) && !intr
                        && (dma_size != 32'd0) && !drain_q;
   assign burst_done  = (state_q == WR_DATA) && bus.wr_ready
                        && (beat_q == LAST);

   assign bus.rd_req_addr = src_base + tail_ptr + offset_q;
   assign bus.wr_req_addr = dest_base + tail_ptr + offset_q;
   assign bus.rd_req_len  = 5'(BURST_BEATS - 1);
   assign bus.wr_req_len  = 5'(BURST_BEATS - 1);
   assign bus.wr_data     = data_buf[beat_q];

   // High for exactly one cycle after reset to flush beats left on the bus
   always_ff @(posedge clk) drain_q <= rst;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d          = state_q;
      bus.rd_req_valid = 1'b0;
      bus.rd_ready     = drain_q;
      bus.wr_req_valid = 1'b0;
      bus.wr_valid     = 1'b0;
      bus.wr_last      = 1'b0;
      unique case (state_q)
         IDLE: if (start) state_d = RD_REQ;
         RD_REQ: begin
            bus.rd_req_valid = 1'b1;
            if (bus.rd_req_ready) state_d = RD_DATA;
         end
         RD_DATA: begin
            bus.rd_ready = 1'b1;
            if (bus.rd_valid && bus.rd_last) state_d = WR_REQ;
         end
         WR_REQ: begin
            bus.wr_req_valid = 1'b1;
            if (bus.wr_req_ready) state_d = WR_DATA;
         end
         WR_DATA: begin
            bus.wr_valid = 1'b1;
            bus.wr_last  = (beat_q == LAST);
            if (burst_done)
               state_d = (offset_next >= dma_size) ? DONE : RD_REQ;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         offset_q <= '0;
         beat_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: if (start) offset_q <= '0;
            RD_DATA: begin
               if (bus.rd_valid) beat_q <= bus.rd_last ? '0 : beat_inc;
            end
            WR_DATA: begin
               if (bus.wr_ready) beat_q <= beat_inc;
               if (burst_done) offset_q <= offset_next;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == RD_DATA && bus.rd_valid) data_buf[beat_q] <= bus.rd_rdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         src_base  <= '0;
         dest_base <= '0;
         tail_ptr  <= '0;
         head_ptr  <= '0;
         dma_size  <= '0;
         ctrl_stat <= '0;
      end else begin
         unique case (1'b1)
            reg_wr_en[0]: src_base  <= reg_wr_data;
            reg_wr_en[1]: dest_base <= reg_wr_data;
            reg_wr_en[2]: tail_ptr  <= reg_wr_data;
            reg_wr_en[3]: head_ptr  <= reg_wr_data;
            reg_wr_en[4]: dma_size  <= reg_wr_data;
            reg_wr_en[5]: ctrl_stat <= reg_wr_data;
            default: ;
         endcase
         // Completion overrides a same-cycle CPU write so no interrupt is lost
         if (state_q == DONE) begin
            tail_ptr      <= (tail_ptr + dma_size) & RING_MASK;
            ctrl_stat[31] <= 1'b1;
         end
      end
   end

`ifdef DMA_PERF_CNT_EN
   logic perf_clr;
   assign perf_clr = rst | (reg_wr_en[5] & reg_wr_data[1]);

   always_ff @(posedge clk) begin
      if (perf_clr) begin
         perf_cycles <= '0;
         perf_bursts <= '0;
      end else begin
         if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 1'b1;
         if (burst_done && perf_bursts != '1) perf_bursts <= perf_bursts + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_dma_ring_engine.sv
// tb_dma_ring_engine: directed scenarios for the ring DMA engine,
// with the bench acting as the memory fabric.
module tb_dma_ring_engine;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [5:0]  reg_wr_en;
   logic [31:0] reg_wr_data;
   logic [31:0] src_base, dest_base, tail_ptr, head_ptr, dma_size, ctrl_stat;
   logic        intr, busy;
`ifdef DMA_PERF_CNT_EN
   logic [31:0] perf_cycles, perf_bursts;
`endif
   int vectors = 0;
   int miscompares = 0;

   dma_ring_engine_if #(.DATA_WIDTH(32)) bus ();

   dma_ring_engine #(
      .DATA_WIDTH(32), .BURST_BEATS(8), .RING_BYTES(4096)
   ) dut (
      .clk(clk), .rst(rst),
      .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
      .src_base(src_base), .dest_base(dest_base),
      .tail_ptr(tail_ptr), .head_ptr(head_ptr),
      .dma_size(dma_size), .ctrl_stat(ctrl_stat),
      .intr(intr), .busy(busy),
`ifdef DMA_PERF_CNT_EN
      .perf_cycles(perf_cycles), .perf_bursts(perf_bursts),
`endif
      .bus(bus)
   );

   function automatic logic [31:0] pat(input logic [31:0] a, input int b);
      return {a[15:0], 16'(b)} ^ 32'h5A5A_0000;
   endfunction

   task automatic wr_reg(input int idx, input logic [31:0] v);
      reg_wr_en   = 6'(1 << idx);
      reg_wr_data = v;
      @(negedge clk);
      reg_wr_en   = '0;
   endtask

   task automatic do_read(input int hold, output logic [31:0] addr,
                          output bit stable, output bit ok);
      int n = 0;
      addr = '0; stable = 1'b1; ok = 1'b1;
      while (!bus.rd_req_valid && n < 50) begin
         @(negedge clk); n++;
      end
      if (!bus.rd_req_valid) begin ok = 1'b0; return; end
      addr = bus.rd_req_addr;
      repeat (hold) begin
         @(negedge clk);
         if (!bus.rd_req_valid || bus.rd_req_addr !== addr) stable = 1'b0;
      end
      bus.rd_req_ready = 1'b1;
      @(negedge clk);
      bus.rd_req_ready = 1'b0;
      for (int b = 0; b < 8; b++) begin
         bus.rd_rdata = pat(addr, b);
         bus.rd_valid = 1'b1;
         bus.rd_last  = (b == 7);
         @(negedge clk);
      end
      bus.rd_valid = 1'b0;
      bus.rd_last  = 1'b0;
   endtask

   task automatic do_write(input bit toggle, output logic [31:0] addr,
                           output logic [7:0][31:0] data,
                           output logic [7:0] lastm, output bit ok);
      int n = 0;
      int got = 0;
      bit tog = 1'b1;
      addr = '0; data = '0; lastm = '0; ok = 1'b1;
      while (!bus.wr_req_valid && n < 50) begin
         @(negedge clk); n++;
      end
      if (!bus.wr_req_valid) begin ok = 1'b0; return; end
      addr = bus.wr_req_addr;
      bus.wr_req_ready = 1'b1;
      @(negedge clk);
      bus.wr_req_ready = 1'b0;
      n = 0;
      while (got < 8 && n < 100) begin
         bus.wr_ready = toggle ? tog : 1'b1;
         if (bus.wr_valid && bus.wr_ready) begin
            data[got]  = bus.wr_data;
            lastm[got] = bus.wr_last;
            got++;
         end
         @(negedge clk);
         n++;
         tog = !tog;
      end
      bus.wr_ready = 1'b0;
      ok = (got == 8);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({src_base, dest_base, tail_ptr, head_ptr, dma_size, ctrl_stat} !== '0) begin
         miscompares++;
         $display("FAIL reset_regs got=%h/%h/%h exp=0", tail_ptr, head_ptr, ctrl_stat);
      end
      vectors++;
      if ({bus.rd_req_valid, bus.wr_req_valid, bus.wr_valid, busy, intr} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_valids got=%b exp=00000",
                  {bus.rd_req_valid, bus.wr_req_valid, bus.wr_valid, busy, intr});
      end
      rst = 1'b0;
      vectors++;
      if (bus.rd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_drain got=%b exp=1", bus.rd_ready);
      end
      @(negedge clk);
      vectors++;
      if (bus.rd_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_drain_end got=%b exp=0", bus.rd_ready);
      end
   endtask

   task automatic test_basic;
      logic [31:0] ra, wa;
      logic [7:0][31:0] d;
      logic [7:0] lm;
      bit st, ok1, ok2, seen;
      wr_reg(0, 32'h1000);
      wr_reg(1, 32'h8000);
      wr_reg(4, 32'h40);
      wr_reg(2, 32'h0);
      wr_reg(3, 32'h40);
      vectors++;
      if (src_base !== 32'h1000 || head_ptr !== 32'h40) begin
         miscompares++;
         $display("FAIL basic_regwr got=%h/%h exp=1000/40", src_base, head_ptr);
      end
      wr_reg(5, 32'h1);
      for (int k = 0; k < 2; k++) begin
         do_read(0, ra, st, ok1);
         do_write(1'b0, wa, d, lm, ok2);
         vectors++;
         if (!(ok1 && ok2) || ra !== 32'h1000 + 32'(k * 32)
             || wa !== 32'h8000 + 32'(k * 32)) begin
            miscompares++;
            $display("FAIL basic_addr%0d got=%h/%h exp=%h/%h", k, ra, wa,
                     32'h1000 + 32'(k * 32), 32'h8000 + 32'(k * 32));
         end
         for (int b = 0; b < 8; b++) begin
            vectors++;
            if (d[b] !== pat(32'h1000 + 32'(k * 32), b)) begin
               miscompares++;
               $display("FAIL basic_data%0d_%0d got=%h exp=%h", k, b, d[b],
                        pat(32'h1000 + 32'(k * 32), b));
            end
         end
         vectors++;
         if (lm !== 8'h80) begin
            miscompares++;
            $display("FAIL basic_last%0d got=%h exp=80", k, lm);
         end
      end
      @(negedge clk);
      vectors++;
      if (tail_ptr !== 32'h40 || intr !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_done got=%h/%b/%b exp=40/1/0", tail_ptr, intr, busy);
      end
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.rd_req_valid) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_extra_req got=%b exp=0", seen);
      end
   endtask

   task automatic test_wrap;
      logic [31:0] ra, wa;
      logic [7:0][31:0] d;
      logic [7:0] lm;
      bit st, ok1, ok2, seen;
      wr_reg(2, 32'hFE0);
      wr_reg(4, 32'h20);
      wr_reg(3, 32'h0);
      wr_reg(5, 32'h1);
      do_read(0, ra, st, ok1);
      do_write(1'b0, wa, d, lm, ok2);
      vectors++;
      if (!(ok1 && ok2) || ra !== 32'h1FE0 || wa !== 32'h8FE0) begin
         miscompares++;
         $display("FAIL wrap_addr got=%h/%h exp=1fe0/8fe0", ra, wa);
      end
      vectors++;
      if (d[7] !== pat(32'h1FE0, 7)) begin
         miscompares++;
         $display("FAIL wrap_data got=%h exp=%h", d[7], pat(32'h1FE0, 7));
      end
      @(negedge clk);
      vectors++;
      if (tail_ptr !== 32'h0 || intr !== 1'b1) begin
         miscompares++;
         $display("FAIL wrap_tail got=%h/%b exp=0/1", tail_ptr, intr);
      end
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.rd_req_valid || busy) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL wrap_idle got=%b exp=0", seen);
      end
   endtask

   task automatic test_intr_backpressure;
      logic [31:0] ra, wa;
      logic [7:0][31:0] d;
      logic [7:0] lm;
      bit st, ok1, ok2, seen;
      wr_reg(3, 32'h40);
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.rd_req_valid) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL intr_gate got=%b exp=0", seen);
      end
      wr_reg(5, 32'h1);
      do_read(5, ra, st, ok1);
      vectors++;
      if (!ok1 || ra !== 32'h1000 || st !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_rd_addr got=%h stable=%b exp=1000/1", ra, st);
      end
      do_write(1'b1, wa, d, lm, ok2);
      vectors++;
      if (!ok2 || wa !== 32'h8000) begin
         miscompares++;
         $display("FAIL bp_wr_addr got=%h exp=8000", wa);
      end
      for (int b = 0; b < 8; b++) begin
         vectors++;
         if (d[b] !== pat(32'h1000, b)) begin
            miscompares++;
            $display("FAIL bp_data_%0d got=%h exp=%h", b, d[b], pat(32'h1000, b));
         end
      end
      vectors++;
      if (lm !== 8'h80) begin
         miscompares++;
         $display("FAIL bp_last got=%h exp=80", lm);
      end
      @(negedge clk);
      vectors++;
      if (tail_ptr !== 32'h20) begin
         miscompares++;
         $display("FAIL bp_tail got=%h exp=20", tail_ptr);
      end
   endtask

   task automatic test_race;
      logic [31:0] ra, wa;
      logic [7:0][31:0] d;
      logic [7:0] lm;
      bit st, ok1, ok2;
      wr_reg(5, 32'h1);
      do_read(0, ra, st, ok1);
      do_write(1'b0, wa, d, lm, ok2);
      vectors++;
      if (!(ok1 && ok2) || ra !== 32'h1020 || busy !== 1'b1 || bus.wr_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL race_setup got=%h/%b/%b exp=1020/1/0", ra, busy, bus.wr_valid);
      end
      wr_reg(5, 32'h1);
      vectors++;
      if (ctrl_stat !== 32'h8000_0001) begin
         miscompares++;
         $display("FAIL race_ctrl got=%h exp=80000001", ctrl_stat);
      end
      vectors++;
      if (tail_ptr !== 32'h40) begin
         miscompares++;
         $display("FAIL race_tail got=%h exp=40", tail_ptr);
      end
   endtask

   task automatic test_reset_mid_burst;
      logic [31:0] ra;
      bit st, ok1;
      int n = 0;
      wr_reg(3, 32'h60);
      wr_reg(5, 32'h1);
      do_read(0, ra, st, ok1);
      while (!bus.wr_req_valid && n < 50) begin
         @(negedge clk); n++;
      end
      bus.wr_req_ready = 1'b1;
      @(negedge clk);
      bus.wr_req_ready = 1'b0;
      bus.wr_ready = 1'b1;
      repeat (3) @(negedge clk);
      bus.wr_ready = 1'b0;
      vectors++;
      if (!ok1 || ra !== 32'h1040 || bus.wr_valid !== 1'b1
          || bus.wr_data !== pat(32'h1040, 3)) begin
         miscompares++;
         $display("FAIL rstmid_beat3 got=%h/%b/%h exp=1040/1/%h", ra,
                  bus.wr_valid, bus.wr_data, pat(32'h1040, 3));
      end
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if ({bus.rd_req_valid, bus.wr_req_valid, bus.wr_valid, busy} !== 4'b0) begin
         miscompares++;
         $display("FAIL rstmid_valids got=%b exp=0000",
                  {bus.rd_req_valid, bus.wr_req_valid, bus.wr_valid, busy});
      end
      vectors++;
      if ({src_base, dest_base, tail_ptr, head_ptr, dma_size, ctrl_stat} !== '0) begin
         miscompares++;
         $display("FAIL rstmid_regs got=%h/%h/%h exp=0", src_base, tail_ptr, ctrl_stat);
      end
      rst = 1'b0;
      vectors++;
      if (bus.rd_ready !== 1'b1 || bus.rd_req_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rstmid_drain got=%b/%b exp=1/0", bus.rd_ready, bus.rd_req_valid);
      end
      @(negedge clk);
      vectors++;
      if (bus.rd_ready !== 1'b0 || bus.rd_req_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rstmid_after got=%b/%b exp=0/0", bus.rd_ready, bus.rd_req_valid);
      end
   endtask

`ifdef DMA_PERF_CNT_EN
   task automatic test_perf;
      logic [31:0] ra, wa;
      logic [7:0][31:0] d;
      logic [7:0] lm;
      bit st, ok1, ok2;
      wr_reg(0, 32'h1000);
      wr_reg(1, 32'h8000);
      wr_reg(4, 32'h40);
      wr_reg(3, 32'h40);
      wr_reg(5, 32'h1);
      repeat (2) begin
         do_read(0, ra, st, ok1);
         do_write(1'b0, wa, d, lm, ok2);
      end
      @(negedge clk);
      vectors++;
      if (perf_bursts !== 32'd2 || perf_cycles !== 32'd37) begin
         miscompares++;
         $display("FAIL perf_counts got=%0d/%0d exp=2/37", perf_bursts, perf_cycles);
      end
      wr_reg(5, 32'h2);
      vectors++;
      if (perf_bursts !== 32'd0 || perf_cycles !== 32'd0) begin
         miscompares++;
         $display("FAIL perf_clear got=%0d/%0d exp=0/0", perf_bursts, perf_cycles);
      end
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reg_wr_en        = '0;
      reg_wr_data      = '0;
      bus.rd_req_ready = 1'b0;
      bus.rd_rdata     = '0;
      bus.rd_valid     = 1'b0;
      bus.rd_last      = 1'b0;
      bus.wr_req_ready = 1'b0;
      bus.wr_ready     = 1'b0;
      test_reset();
      test_basic();
      test_wrap();
      test_intr_backpressure();
      test_race();
      test_reset_mid_burst();
`ifdef DMA_PERF_CNT_EN
      test_perf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
